mpadder_arbiter: RTL and testbench
==================================

Name: mpadder_arbiter

Overview:
- Shares one mpadder instance (1027-bit add, 1028-bit result, start/done protocol) between two requesters, such as the two halves of a modular-exponentiation datapath.
- Arbitrates requests round-robin and registers the winner's operands.
- Sequences the adder's start/done handshake and returns the registered sum to the winner.
- Watchdog timer flags an adder that never asserts done.

Parameters:
- WIDTH, 1027, operand width; result width is WIDTH+1.
- TIMEOUT, 15, maximum cycles in WAIT before an error is raised (4-bit counter, 1..15).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0, req1  in  1 each  requester n wants an operation; held high with operands stable until its ack.
- sub0, sub1  in  1 each  subtract flag of requester n.
- a0, b0, a1, b1  in  WIDTH each  operands of requester n.
- ack0, ack1  out  1 each  one-cycle pulse: result/err for requester n valid this cycle.
- res  out  WIDTH+1  registered result, shared by both requesters.
- err  out  1  registered; high together with the ack of a timed-out operation.
- busy  out  1  high whenever state != IDLE.
- add_start  out  1  to mpadder start.
- add_sub  out  1  to mpadder subtract.
- add_a, add_b  out  WIDTH each  to mpadder in_a/in_b, driven from internal registers.
- add_result  in  WIDTH+1  from mpadder result.
- add_done  in  1  from mpadder done.

Behaviour:
Reset:
- All outputs and registers clear to 0; state = IDLE; round-robin pointer last = 1, so req0 wins first.
- Asserting reset mid-operation aborts it immediately: no ack and no err.
- The mpadder's own reset is driven by the system, outside this block.

States: IDLE, ISSUE, WAIT, RESP (2-bit encoding).
- IDLE: if no request, stay.
  - If exactly one req is high, grant it.
  - If both are high, grant the requester that is not `last`.
  - On grant, latch the winner's a/b/sub into add_a/add_b/add_sub, record the winner in gnt_id, set last = winner, and go to ISSUE.
- ISSUE: add_start = 1 for exactly this cycle; go to WAIT and clear the timeout counter.
- WAIT: add_start = 0.
  - If add_done = 1: capture add_result into res, err = 0, go to RESP.
  - Otherwise, increment the counter. When the counter reaches TIMEOUT-1 without done: res = 0, err = 1, go to RESP.
- RESP: assert ack[gnt_id] for one cycle while holding res/err; go to IDLE.
  - res/err remain stable until the next capture.
  - err clears on the next successful capture.

Timing and handshake:
- Latency with the standard mpadder: req sampled in IDLE at cycle T; add_start at T+1; add_done at T+3; ack at T+4. This gives one operation per 5 cycles.
- A requester deasserts req in the cycle after its ack. A req still high in the IDLE cycle after RESP is treated as a new request and is granted again.
- req asserted while busy is held pending and is not lost. The loser of a simultaneous request is served next.
- add_a/add_b/add_sub are held constant from the grant until the next grant, because mpadder reloads its inputs every idle cycle.
- A late add_done arriving in IDLE/ISSUE after a timeout is ignored.
- ack0 and ack1 are never high together; at most one ack per operation.
- Widths: no arithmetic inside this block; res is exactly add_result (WIDTH+1 bits, carry at MSB).

Test Plan:
- Single request: req0=1, a0=5, b0=7, sub0=0 → add_start pulse at T+1, ack0 at T+4, res=12, err=0, ack1 never high.
- Carry out: req1 with a1=b1=2^1027-1 → res=2^1028-2 (bit 1027 set), ack1 only.
- Simultaneous after reset: req0 and req1 high in the same cycle → req0 served first (ack0 at T+4), req1 granted in the following IDLE and acked 5 cycles later. Repeat the simultaneous requests → req0 wins again, since last=1 after serving req1.
- Pending request: req1 rises while busy serving req0 → req1 granted in the first IDLE cycle after ack0; add_a switches to a1 only at that grant.
- Timeout: add_done tied to 0 → ack0 with err=1 and res=0 TIMEOUT cycles after entering WAIT. A following normal op then returns err=0.
- Reset mid-operation: assert reset during WAIT → busy, ack0/ack1, err, add_start all 0 asynchronously. After release, a new req1 completes normally with correct res.

Source files
------------

// File: rtl/mpadder_arbiter.sv
// Round-robin arbiter sharing one multi-precision adder between two requesters.
// Registers the winner's operands, sequences start/done, and flags a hung adder.
module mpadder_arbiter #(
    parameter int unsigned WIDTH   = 1027,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             sub0,
    input  logic             sub1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH:0]   res,
    output logic             err,
    output logic             busy,
    output logic             add_start,
    output logic             add_sub,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH:0]   add_result,
    input  logic             add_done
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             gnt_q, gnt_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             sub_q, sub_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   res_q, res_d;
    logic             err_q, err_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             win;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            err_q   <= err_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
        end
    end

    // Next-state logic; strobes are derived from the next state so they line up with it.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        err_d   = err_q;
        win     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    win     = (req0 && req1) ? ~last_q : req1;
                    gnt_d   = win;
                    last_d  = win;
                    a_d     = win ? a1 : a0;
                    b_d     = win ? b1 : b0;
                    sub_d   = win ? sub1 : sub0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (add_done) begin
                    res_d   = add_result;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        start_d = (state_d == ISSUE);
        busy_d  = (state_d != IDLE);
        ack0_d  = (state_d == RESP) && !gnt_d;
        ack1_d  = (state_d == RESP) && gnt_d;
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign res       = res_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign add_start = start_q;
    assign add_sub   = sub_q;
    assign add_a     = a_q;
    assign add_b     = b_q;

endmodule

// File: tb/tb_mpadder_arbiter.sv
// Bench for mpadder_arbiter: behavioural adder model, scoreboard of expected acks,
// vector table plus directed sequences for latency, fairness, timeout and reset.
module tb_mpadder_arbiter;

    localparam int unsigned W  = 1027;
    localparam int unsigned TO = 15;

    logic         clk, reset;
    logic         req0, req1, sub0, sub1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         ack0, ack1, err, busy, add_start, add_sub, add_done;
    logic [W:0]   res, add_result;
    logic [W-1:0] add_a, add_b;

    int n_cmp = 0;
    int n_bad = 0;
    logic hang;
    logic pend;

    typedef struct {
        logic       id;
        logic [W:0] res;
        logic       err;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    typedef struct {
        logic       id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic       sub;
        logic [W:0] exp;
    } vec_t;
    vec_t vecs[6];

    mpadder_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .sub0(sub0), .sub1(sub1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1), .res(res), .err(err), .busy(busy),
        .add_start(add_start), .add_sub(add_sub), .add_a(add_a), .add_b(add_b),
        .add_result(add_result), .add_done(add_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Standard mpadder behaviour: done two cycles after start is seen.
    always @(posedge clk) begin
        add_done <= 1'b0;
        if (pend && !hang) begin
            add_done   <= 1'b1;
            add_result <= add_sub ? ({1'b0, add_a} - {1'b0, add_b}) : ({1'b0, add_a} + {1'b0, add_b});
        end
        pend <= add_start;
    end

    task automatic chk(input string name, input logic [W:0] got, input logic [W:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_b(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b", name, got, exp);
        end
    endtask

    task automatic chk_i(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Scoreboard: every ack pops the oldest expectation.
    always @(negedge clk) begin
        if (ack0 && ack1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL both_acks: got ack0=1 ack1=1 expected at most one");
        end else if (ack0 || ack1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b expected none", ack0, ack1);
            end else begin
                mon_e = sb.pop_front();
                chk_b("ack_id", ack1, mon_e.id);
                chk("ack_res", res, mon_e.res);
                chk_b("ack_err", err, mon_e.err);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        if (id) begin
            a1 = a; b1 = b; sub1 = sub; req1 = 1'b1;
        end else begin
            a0 = a; b0 = b; sub0 = sub; req0 = 1'b1;
        end
    endtask

    task automatic push(input logic id, input logic [W:0] r, input logic e);
        exp_t x;
        x.id = id; x.res = r; x.err = e;
        sb.push_back(x);
    endtask

    // Waits for the requester's ack; k counts negedges seen, starting at 1.
    task automatic wait_ack(input logic id, output int k);
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (id ? ack1 : ack0) begin
                k = i;
                return;
            end
        end
        k = -1;
        n_cmp++;
        n_bad++;
        $display("FAIL ack_timeout: got no ack%0d expected ack within 60 cycles", id);
    endtask

    task automatic drop(input logic id);
        step();
        if (id) req1 = 1'b0; else req0 = 1'b0;
    endtask

    task automatic do_op(input vec_t v, input logic e);
        int k;
        drive(v.id, v.a, v.b, v.sub);
        push(v.id, v.exp, e);
        wait_ack(v.id, k);
        drop(v.id);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        sb.delete();
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        logic [W-1:0] ones;
        logic [W:0]   ones1;
        logic [W-1:0] one;
        logic [W-1:0] ra, rb;
        vec_t v;
        int k;

        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; sub0 = 1'b0; sub1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        hang = 1'b0; pend = 1'b0; add_done = 1'b0; add_result = '0;

        ones  = '1;
        ones1 = '1;
        one   = W'(1);
        ra    = W'($urandom);
        rb    = W'($urandom);
        ra[W-1] = 1'b1;
        rb[W-1] = 1'b1;
        vecs[0] = '{1'b0, W'(5), W'(7), 1'b0, (W+1)'(12)};
        vecs[1] = '{1'b1, ones, ones, 1'b0, {1'b1, {(W-1){1'b1}}, 1'b0}};
        vecs[2] = '{1'b0, W'(10), W'(3), 1'b1, (W+1)'(7)};
        vecs[3] = '{1'b1, W'(3), W'(10), 1'b1, ones1 - (W+1)'(6)};
        vecs[4] = '{1'b0, one << (W-1), one << (W-1), 1'b0, (W+1)'(1) << W};
        vecs[5] = '{1'b1, ra, rb, 1'b0, {1'b0, ra} + {1'b0, rb}};

        // Reset state
        @(negedge clk);
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_ack0", ack0, 1'b0);
        chk_b("rst_ack1", ack1, 1'b0);
        chk_b("rst_err", err, 1'b0);
        chk_b("rst_start", add_start, 1'b0);
        chk("rst_res", res, '0);
        chk("rst_add_a", {1'b0, add_a}, '0);
        step();
        reset = 1'b0;
        step();

        // Single request latency: start at T+1, ack at T+4
        drive(1'b0, W'(5), W'(7), 1'b0);
        push(1'b0, (W+1)'(12), 1'b0);
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            chk_b($sformatf("lat_start_%0d", c), add_start, c == 1);
            chk_b($sformatf("lat_ack0_%0d", c), ack0, c == 4);
            chk_b($sformatf("lat_ack1_%0d", c), ack1, 1'b0);
            chk_b($sformatf("lat_busy_%0d", c), busy, (c >= 1) && (c <= 4));
            if (c == 4) drop(1'b0);
        end

        // Vector table
        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i], 1'b0);
            step();
        end

        // Simultaneous requests after reset: req0 first, req1 five cycles later, twice
        reset_dut();
        for (int r = 0; r < 2; r++) begin
            drive(1'b0, W'(1), W'(2), 1'b0);
            drive(1'b1, W'(100), W'(200), 1'b0);
            push(1'b0, (W+1)'(3), 1'b0);
            push(1'b1, (W+1)'(300), 1'b0);
            wait_ack(1'b0, k);
            drop(1'b0);
            wait_ack(1'b1, k);
            chk_i($sformatf("simul_gap_%0d", r), k, 5);
            drop(1'b1);
            step();
        end

        // Pending request while busy; add_a switches only at the new grant
        drive(1'b0, W'(11), W'(22), 1'b0);
        push(1'b0, (W+1)'(33), 1'b0);
        step();
        step();
        drive(1'b1, W'(44), W'(55), 1'b0);
        push(1'b1, (W+1)'(99), 1'b0);
        wait_ack(1'b0, k);
        chk("pend_add_a_resp", {1'b0, add_a}, (W+1)'(11));
        drop(1'b0);
        @(negedge clk);
        chk("pend_add_a_idle", {1'b0, add_a}, (W+1)'(11));
        chk_b("pend_busy_idle", busy, 1'b0);
        @(negedge clk);
        chk("pend_add_a_grant", {1'b0, add_a}, (W+1)'(44));
        chk_b("pend_start", add_start, 1'b1);
        wait_ack(1'b1, k);
        drop(1'b1);
        step();

        // Timeout: ack with err=1, res=0, TIMEOUT cycles after entering WAIT
        hang = 1'b1;
        drive(1'b0, W'(9), W'(9), 1'b0);
        push(1'b0, '0, 1'b1);
        wait_ack(1'b0, k);
        chk_i("timeout_cycles", k, TO + 3);
        drop(1'b0);
        hang = 1'b0;
        step();
        v = '{1'b0, W'(1), W'(1), 1'b0, (W+1)'(2)};
        do_op(v, 1'b0);
        step();

        // Reset mid-operation, with err left high by a second timeout
        hang = 1'b1;
        drive(1'b1, W'(9), W'(9), 1'b0);
        push(1'b1, '0, 1'b1);
        wait_ack(1'b1, k);
        drop(1'b1);
        hang = 1'b0;
        step();
        drive(1'b0, W'(5), W'(5), 1'b0);
        step();
        step();
        chk_b("mid_busy_before", busy, 1'b1);
        chk_b("mid_err_before", err, 1'b1);
        #2;
        reset = 1'b1;
        req0 = 1'b0;
        #1;
        chk_b("mid_busy", busy, 1'b0);
        chk_b("mid_start", add_start, 1'b0);
        chk_b("mid_ack0", ack0, 1'b0);
        chk_b("mid_ack1", ack1, 1'b0);
        chk_b("mid_err", err, 1'b0);
        step();
        step();
        reset = 1'b0;
        step();
        step();
        step();
        do_op(vecs[1], 1'b0);
        step();
        step();
        chk_i("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
